// File: rtl/multi_button_processor.sv
// Per-channel pushbutton processor: two-flop synchroniser, debounce, and short/long
// press classification with optional auto-repeat of the long-press pulse.
module multi_button_processor #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_TIME   = 20,
  parameter int LONG_PRESS_TIME = 1500,
  parameter int REPEAT_TIME     = 250,
  parameter int CNT_W           = 11
) (
  input  logic                 clk_1khz,
  input  logic                 rst_i,
  input  logic [N_BUTTONS-1:0] pushbutton_i,
  output logic [N_BUTTONS-1:0] count_up,
  output logic [N_BUTTONS-1:0] count_down,
  output logic [N_BUTTONS-1:0] pressed_o
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DEBOUNCING = 2'd1,
    S_PRESSED    = 2'd2,
    S_LONG_PRESS = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TIME - 1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_TIME - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'((REPEAT_TIME > 0) ? (REPEAT_TIME - 1) : 0);
  localparam bit               RP_EN   = (REPEAT_TIME > 0);

  logic [N_BUTTONS-1:0] r_sync_p0;
  logic [N_BUTTONS-1:0] r_sync_p1;
  state_t               r_state [N_BUTTONS];
  logic [CNT_W-1:0]     r_cnt   [N_BUTTONS];

  // Stage p0/p1: metastability guard on the raw pins
  always_ff @(posedge clk_1khz or posedge rst_i) begin
    if (rst_i) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= pushbutton_i;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Stage p2: per-channel press classifier, outputs registered alongside state
  always_ff @(posedge clk_1khz or posedge rst_i) begin
    if (rst_i) begin
      count_up   <= '0;
      count_down <= '0;
      pressed_o  <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        count_up[i]   <= 1'b0;
        count_down[i] <= 1'b0;
        case (r_state[i])
          S_IDLE: begin
            r_cnt[i]     <= '0;
            pressed_o[i] <= 1'b0;
            if (r_sync_p1[i]) r_state[i] <= S_DEBOUNCING;
          end
          S_DEBOUNCING: begin
            if (!r_sync_p1[i]) begin
              r_state[i] <= S_IDLE;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == DB_LAST) begin
              r_state[i]   <= S_PRESSED;
              r_cnt[i]     <= '0;
              pressed_o[i] <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
          S_PRESSED: begin
            if (!r_sync_p1[i]) begin
              r_state[i]   <= S_IDLE;
              r_cnt[i]     <= '0;
              pressed_o[i] <= 1'b0;
              count_up[i]  <= 1'b1;
            end else if (r_cnt[i] == LP_LAST) begin
              r_state[i]    <= S_LONG_PRESS;
              r_cnt[i]      <= '0;
              count_down[i] <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
          S_LONG_PRESS: begin
            if (!r_sync_p1[i]) begin
              r_state[i]   <= S_IDLE;
              r_cnt[i]     <= '0;
              pressed_o[i] <= 1'b0;
            end else if (RP_EN && (r_cnt[i] == RP_LAST)) begin
              r_cnt[i]      <= '0;
              count_down[i] <= 1'b1;
            end else if (RP_EN) begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else begin
              r_cnt[i] <= '0;
            end
          end
          default: begin
            r_state[i]   <= S_IDLE;
            r_cnt[i]     <= '0;
            pressed_o[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_button_processor.sv
// Bench for multi_button_processor: run-length reference model plus directed
// latency scenarios and randomized button activity with asynchronous resets.
module tb_multi_button_processor;
  localparam int N  = 4;
  localparam int DT = 4;
  localparam int LP = 10;
  localparam int RT = 5;
  localparam int CW = 11;
  localparam int P_RUN = 1 + DT;       // run length at which a press is accepted
  localparam int L_RUN = 1 + DT + LP;  // run length at which the long press fires

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pin = '0;
  logic [N-1:0] up, dn, pr, up0, dn0, pr0;

  always #5 clk = ~clk;

  multi_button_processor #(.N_BUTTONS(N), .DEBOUNCE_TIME(DT), .LONG_PRESS_TIME(LP),
                           .REPEAT_TIME(RT), .CNT_W(CW)) u_dut (
    .clk_1khz(clk), .rst_i(rst), .pushbutton_i(pin),
    .count_up(up), .count_down(dn), .pressed_o(pr));

  multi_button_processor #(.N_BUTTONS(N), .DEBOUNCE_TIME(DT), .LONG_PRESS_TIME(LP),
                           .REPEAT_TIME(0), .CNT_W(CW)) u_dut_norep (
    .clk_1khz(clk), .rst_i(rst), .pushbutton_i(pin),
    .count_up(up0), .count_down(dn0), .pressed_o(pr0));

  // Reference: the classifier only depends on how many consecutive edges the
  // two-edge-delayed pin has been seen high.
  logic [N-1:0] d1 = '0, d2 = '0;
  logic [N-1:0] e_up = '0, e_dn = '0, e_dn0 = '0, e_pr = '0;
  int           run [N];
  int           ecount = 0;

  function automatic logic down_hit(int r, int rt);
    return (r == L_RUN) || ((rt != 0) && (r > L_RUN) && (((r - L_RUN) % rt) == 0));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0; d2 <= '0;
      e_up <= '0; e_dn <= '0; e_dn0 <= '0; e_pr <= '0;
      for (int i = 0; i < N; i++) run[i] <= 0;
    end else begin
      ecount <= ecount + 1;
      for (int i = 0; i < N; i++) begin
        int r;
        r = run[i];
        if (d2[i]) begin
          r = r + 1;
          e_up[i]  <= 1'b0;
          e_dn[i]  <= down_hit(r, RT);
          e_dn0[i] <= down_hit(r, 0);
          e_pr[i]  <= (r >= P_RUN);
        end else begin
          e_up[i]  <= (r >= P_RUN) && (r < L_RUN);
          e_dn[i]  <= 1'b0;
          e_dn0[i] <= 1'b0;
          e_pr[i]  <= 1'b0;
          r = 0;
        end
        run[i] <= r;
      end
      d2 <= d1;
      d1 <= pin;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("count_up",         32'(up),  32'(e_up));
    chk("count_down",       32'(dn),  32'(e_dn));
    chk("pressed_o",        32'(pr),  32'(e_pr));
    chk("norep.count_up",   32'(up0), 32'(e_up));
    chk("norep.count_down", 32'(dn0), 32'(e_dn0));
    chk("norep.pressed_o",  32'(pr0), 32'(e_pr));
  endtask

  task automatic idle(input int n);
    pin = '0;
    repeat (n) @(negedge clk);
  endtask

  int base, e;
  int fp0, fup0, nup0, ndn0, ch1_act, nup2, fup_a, ndn3, fdn3, nup3, fpr1, ndn_rep, ndn_norep, fdn_norep;
  int dn2e[$];
  int dur [N];

  initial begin
    fork
      forever begin
        @(negedge clk);
        cmp_all();
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.outputs", {20'd0, up, dn, pr}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Short press ch0, glitch ch1, long press ch2 in parallel
    base = ecount; pin = 4'b0111;
    fp0 = -1; fup0 = -1; nup0 = 0; ndn0 = 0; ch1_act = 0; nup2 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      e = ecount - 1 - base;
      if (pr[0] && fp0 < 0) fp0 = e;
      if (up[0]) begin nup0++; fup0 = e; end
      if (dn[0]) ndn0++;
      if (up[1] || dn[1] || pr[1]) ch1_act++;
      if (dn[2]) dn2e.push_back(e);
      if (up[2]) nup2++;
      pin[0] = (e + 1 <= 8);
      pin[1] = (e + 1 <= 2);
      pin[2] = (e + 1 <= 27);
    end
    chk("short.pressed_edge", 32'(fp0), 32'd6);
    chk("short.up_edge", 32'(fup0), 32'd11);
    chk("short.up_count", 32'(nup0), 32'd1);
    chk("short.no_down", 32'(ndn0), 32'd0);
    chk("glitch.activity", 32'(ch1_act), 32'd0);
    chk("long.down_count", 32'(dn2e.size()), 32'd3);
    if (dn2e.size() == 3) begin
      chk("long.down0", 32'(dn2e[0]), 32'd16);
      chk("long.down1", 32'(dn2e[1]), 32'd21);
      chk("long.down2", 32'(dn2e[2]), 32'd26);
    end
    chk("long.no_up", 32'(nup2), 32'd0);
    idle(10);

    // Overlapping short (ch0) and long (ch3) press with a common release
    base = ecount; pin = 4'b1000;
    fup_a = -1; ndn3 = 0; fdn3 = -1; nup3 = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      e = ecount - 1 - base;
      if (up[0]) fup_a = e;
      if (dn[3]) begin ndn3++; fdn3 = e; end
      if (up[3]) nup3++;
      pin[0] = (e + 1 >= 8) && (e + 1 <= 18);
      pin[3] = (e + 1 <= 18);
    end
    chk("overlap.up0_edge", 32'(fup_a), 32'd21);
    chk("overlap.down3_count", 32'(ndn3), 32'd1);
    chk("overlap.down3_edge", 32'(fdn3), 32'd16);
    chk("overlap.no_up3", 32'(nup3), 32'd0);
    idle(10);

    // Reset while ch1 is held, then the held button is debounced afresh
    base = ecount; pin = 4'b0010;
    fpr1 = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      e = ecount - 1 - base;
      if (e == 10) begin
        chk("midreset.pressed_before", 32'(pr[1]), 32'd1);
        #2 rst = 1'b1;
        #1 chk("midreset.outputs", {8'd0, up, dn, pr, up0, dn0, pr0}, 32'd0);
        #1 rst = 1'b0;
      end else if (e > 10 && pr[1] && fpr1 < 0) begin
        fpr1 = e;
      end
    end
    chk("midreset.repress_edge", 32'(fpr1), 32'd17);
    idle(10);

    // Long hold: repeating build versus no-repeat build
    base = ecount; pin = 4'b0001;
    ndn_rep = 0; ndn_norep = 0; fdn_norep = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      e = ecount - 1 - base;
      if (dn[0]) ndn_rep++;
      if (dn0[0]) begin ndn_norep++; fdn_norep = e; end
      pin[0] = (e + 1 <= 39);
    end
    chk("norep.down_count", 32'(ndn_norep), 32'd1);
    chk("norep.down_edge", 32'(fdn_norep), 32'd16);
    chk("rep.down_count", 32'(ndn_rep), 32'd6);
    idle(10);

    // Randomized activity with occasional asynchronous reset
    for (int i = 0; i < N; i++) dur[i] = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (dur[i] == 0) begin
          pin[i] = ~pin[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 45))
                                               : int'($urandom_range(1, 8));
        end
        dur[i]--;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rand.reset_outputs", {8'd0, up, dn, pr, up0, dn0, pr0}, 32'd0);
        #1 rst = 1'b0;
      end
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
